// File: rtl/cve2_vec_ex_block.sv
// cve2_vec_ex_block: multi-lane integer vector execution stage.
// Takes one vector op (vs2 op vs1/rs1) with SEW 8/16/32 and processes the
// VLEN-bit operands over NBEATS beats of NLANES*32 bits each. Elements past vl,
// and elements with a clear mask bit, keep their old vd value.
// Ports:
//   clk_i, rst_i                  clock, async active-high reset
//   valid_i / ready_o             op request handshake (ready_o = idle)
//   op_i, sew_i, vl_i, vm_i       op code, element width, active length, unmasked flag
//   mask_i, vs1_i, vs2_i, rs1_i   mask bits, vector operands, scalar operand
//   use_scalar_i, vd_i            select rs1 as operand B, old destination value
//   flush_i                       abort any in-flight op
//   valid_o / ready_i             result handshake
//   result_o, illegal_o, busy_o   result vector, illegal op/sew flag, not idle
//
// state | meaning
// IDLE  | waiting for an op, ready_o high
// EXEC  | stepping through beats (MUL takes two cycles per beat)
// DONE  | result held until the consumer takes it
module cve2_vec_ex_block #(
  parameter int VLEN   = 128,
  parameter int NLANES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [3:0]                   op_i,
  input  logic [1:0]                   sew_i,
  input  logic [$clog2(VLEN/8):0]      vl_i,
  input  logic                         vm_i,
  input  logic [VLEN/8-1:0]            mask_i,
  input  logic [VLEN-1:0]              vs1_i,
  input  logic [VLEN-1:0]              vs2_i,
  input  logic [31:0]                  rs1_i,
  input  logic                         use_scalar_i,
  input  logic [VLEN-1:0]              vd_i,
  input  logic                         flush_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [VLEN-1:0]              result_o,
  output logic                         illegal_o,
  output logic                         busy_o
);

  localparam int BEAT_W = NLANES * 32;
  localparam int NBEATS = VLEN / BEAT_W;
  localparam int BEAT_B = BEAT_W / 8;
  localparam int NBYTES = VLEN / 8;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic                phase_q, phase_d;
  logic [VLEN-1:0]     res_q, res_d;
  logic [BEAT_W-1:0]   prod_q, prod_d;
  logic [3:0]          op_q;
  logic [1:0]          sew_q;
  logic                illegal_q;
  logic [VLEN-1:0]     vs2_q, opb_q;
  logic [NBYTES-1:0]   en_q;

  logic                accept;
  logic                illegal_in;
  logic [VLEN-1:0]     opb_in;
  logic [NBYTES-1:0]   en_in;
  logic [BEAT_W-1:0]   a_beat, b_beat, beat_res, wr_data;

  // Operands arrive zero-extended in the low SEW bits; signed views are
  // built here so every op runs on a 32-bit datapath and the caller keeps
  // only the low SEW bits.
  function automatic logic [31:0] elem(input logic [3:0] op, input logic [1:0] sew,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] as, bs;
    logic [4:0]  sh;
    case (sew)
      2'd0: begin
        as = {{24{a[7]}}, a[7:0]};
        bs = {{24{b[7]}}, b[7:0]};
        sh = {2'b00, b[2:0]};
      end
      2'd1: begin
        as = {{16{a[15]}}, a[15:0]};
        bs = {{16{b[15]}}, b[15:0]};
        sh = {1'b0, b[3:0]};
      end
      default: begin
        as = a;
        bs = b;
        sh = b[4:0];
      end
    endcase
    case (op)
      4'd0:    elem = a + b;
      4'd1:    elem = a - b;
      4'd2:    elem = a & b;
      4'd3:    elem = a | b;
      4'd4:    elem = a ^ b;
      4'd5:    elem = a << sh;
      4'd6:    elem = a >> sh;
      4'd7:    elem = $signed(as) >>> sh;
      4'd8:    elem = (a < b) ? a : b;
      4'd9:    elem = ($signed(as) < $signed(bs)) ? a : b;
      4'd10:   elem = (a > b) ? a : b;
      4'd11:   elem = ($signed(as) > $signed(bs)) ? a : b;
      4'd12:   elem = a * b;
      default: elem = '0;
    endcase
  endfunction

  assign ready_o    = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign valid_o    = (state_q == S_DONE);
  assign illegal_o  = valid_o & illegal_q;
  assign result_o   = res_q;
  assign accept     = valid_i & ready_o & ~flush_i;
  assign illegal_in = (op_i > OP_MUL) | (sew_i == 2'b11);

  // Byte-granular write enables: byte k belongs to element k >> sew.
  always_comb begin
    for (int k = 0; k < NBYTES; k++) begin
      int e;
      e = k >> sew_i;
      en_in[k] = (int'(vl_i) > e) && (vm_i || mask_i[e]);
    end
    case (sew_i)
      2'd0:    opb_in = {(VLEN/8){rs1_i[7:0]}};
      2'd1:    opb_in = {(VLEN/16){rs1_i[15:0]}};
      default: opb_in = {(VLEN/32){rs1_i}};
    endcase
    if (!use_scalar_i) opb_in = vs1_i;
  end

  always_comb begin
    logic [31:0] t;
    logic [BEAT_W-1:0] r8, r16, r32;
    a_beat = vs2_q[int'(beat_q)*BEAT_W +: BEAT_W];
    b_beat = opb_q[int'(beat_q)*BEAT_W +: BEAT_W];
    r8  = '0;
    r16 = '0;
    r32 = '0;
    t   = '0;
    for (int j = 0; j < BEAT_W/8; j++) begin
      t = elem(op_q, 2'd0, {24'b0, a_beat[j*8 +: 8]}, {24'b0, b_beat[j*8 +: 8]});
      r8[j*8 +: 8] = t[7:0];
    end
    for (int j = 0; j < BEAT_W/16; j++) begin
      t = elem(op_q, 2'd1, {16'b0, a_beat[j*16 +: 16]}, {16'b0, b_beat[j*16 +: 16]});
      r16[j*16 +: 16] = t[15:0];
    end
    for (int j = 0; j < BEAT_W/32; j++) begin
      t = elem(op_q, 2'd2, a_beat[j*32 +: 32], b_beat[j*32 +: 32]);
      r32[j*32 +: 32] = t;
    end
    case (sew_q)
      2'd0:    beat_res = r8;
      2'd1:    beat_res = r16;
      default: beat_res = r32;
    endcase
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    phase_d = phase_q;
    res_d   = res_q;
    prod_d  = prod_q;
    wr_data = (op_q == OP_MUL) ? prod_q : beat_res;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          res_d   = vd_i;
          beat_d  = '0;
          phase_d = 1'b0;
          state_d = (illegal_in || vl_i == '0) ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL && !phase_q) begin
          // First MUL cycle only registers the products for this beat.
          prod_d  = beat_res;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          for (int k = 0; k < BEAT_B; k++) begin
            if (en_q[int'(beat_q)*BEAT_B + k])
              res_d[int'(beat_q)*BEAT_W + k*8 +: 8] = wr_data[k*8 +: 8];
          end
          if (beat_q == LAST_BEAT) state_d = S_DONE;
          else                     beat_d  = beat_q + 1'b1;
        end
      end
      S_DONE: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      phase_q   <= 1'b0;
      res_q     <= '0;
      prod_q    <= '0;
      op_q      <= '0;
      sew_q     <= '0;
      illegal_q <= 1'b0;
      vs2_q     <= '0;
      opb_q     <= '0;
      en_q      <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
      res_q   <= res_d;
      prod_q  <= prod_d;
      if (accept) begin
        op_q      <= op_i;
        sew_q     <= sew_i;
        illegal_q <= illegal_in;
        vs2_q     <= vs2_i;
        opb_q     <= opb_in;
        en_q      <= en_in;
      end
    end
  end

endmodule

// File: tb/tb_cve2_vec_ex_block.sv
module tb_cve2_vec_ex_block;

  localparam int VLEN   = 128;
  localparam int NLANES = 2;
  localparam int NBEATS = VLEN / (NLANES * 32);
  localparam int NDIR   = 10;
  localparam int NVEC   = NDIR + 40;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          valid_i, ready_o;
  logic [3:0]    op_i;
  logic [1:0]    sew_i;
  logic [4:0]    vl_i;
  logic          vm_i;
  logic [15:0]   mask_i;
  logic [127:0]  vs1_i, vs2_i, vd_i;
  logic [31:0]   rs1_i;
  logic          use_scalar_i, flush_i;
  logic          valid_o, ready_i;
  logic [127:0]  result_o;
  logic          illegal_o, busy_o;

  cve2_vec_ex_block #(.VLEN(VLEN), .NLANES(NLANES)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .sew_i(sew_i), .vl_i(vl_i), .vm_i(vm_i), .mask_i(mask_i),
    .vs1_i(vs1_i), .vs2_i(vs2_i), .rs1_i(rs1_i), .use_scalar_i(use_scalar_i),
    .vd_i(vd_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .illegal_o(illegal_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]   op;
    logic [1:0]   sew;
    logic [4:0]   vl;
    logic         vm;
    logic [15:0]  mask;
    logic [127:0] vs1, vs2, vd;
    logic [31:0]  rs1;
    logic         us;
    logic [127:0] exp_res;
    logic         exp_ill;
    int           exp_lat;
  } vec_t;

  vec_t tbl[NVEC];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] sew, input logic [4:0] vl,
                              input logic vm, input logic [15:0] mask, input logic [127:0] vs1,
                              input logic [127:0] vs2, input logic [31:0] rs1, input logic us,
                              input logic [127:0] vd);
    vec_t v;
    v.op = op; v.sew = sew; v.vl = vl; v.vm = vm; v.mask = mask;
    v.vs1 = vs1; v.vs2 = vs2; v.rs1 = rs1; v.us = us; v.vd = vd;
    v.exp_res = '0; v.exp_ill = 1'b0; v.exp_lat = 0;
    return v;
  endfunction

  // Element-by-element reference: SEW-wide arithmetic on plain integers.
  function automatic logic [127:0] model(input vec_t v);
    logic [127:0] r;
    logic [63:0]  m, a, b, x;
    longint       sa, sb;
    int           w, nel, sh;
    r = v.vd;
    if (v.sew == 2'b11 || v.op > 4'd12) return r;
    w   = 8 << v.sew;
    nel = 128 / w;
    m   = (64'd1 << w) - 1;
    for (int e = 0; e < nel; e++) begin
      a = 64'(v.vs2 >> (e*w)) & m;
      b = v.us ? (64'(v.rs1) & m) : (64'(v.vs1 >> (e*w)) & m);
      sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      sh = int'(b % 64'(w));
      case (v.op)
        4'd0:    x = a + b;
        4'd1:    x = a - b;
        4'd2:    x = a & b;
        4'd3:    x = a | b;
        4'd4:    x = a ^ b;
        4'd5:    x = a << sh;
        4'd6:    x = a >> sh;
        4'd7:    x = 64'(sa >>> sh);
        4'd8:    x = (a < b) ? a : b;
        4'd9:    x = (sa < sb) ? a : b;
        4'd10:   x = (a > b) ? a : b;
        4'd11:   x = (sa > sb) ? a : b;
        default: x = a * b;
      endcase
      x = x & m;
      if (e < int'(v.vl) && (v.vm || v.mask[e]))
        r = (r & ~(128'(m) << (e*w))) | (128'(x) << (e*w));
    end
    return r;
  endfunction

  function automatic int lat_of(input vec_t v);
    if (v.sew == 2'b11 || v.op > 4'd12 || v.vl == 0) return 1;
    if (v.op == 4'd12) return 2*NBEATS + 1;
    return NBEATS + 1;
  endfunction

  task automatic drive(input vec_t v);
    op_i = v.op; sew_i = v.sew; vl_i = v.vl; vm_i = v.vm; mask_i = v.mask;
    vs1_i = v.vs1; vs2_i = v.vs2; rs1_i = v.rs1; use_scalar_i = v.us; vd_i = v.vd;
  endtask

  // Accepts at the next edge; returns cycles from accept edge to the edge valid_o is seen.
  task automatic issue(input vec_t v, output int lat);
    int g = 0;
    while (!ready_o && g < 20) begin @(posedge clk_i); #1; g++; end
    chk("ready_before_issue", 128'(ready_o), 128'(1));
    drive(v);
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 40) begin @(posedge clk_i); #1; lat++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, seen;
    vec_t v;
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    drive(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Directed entries (expected values worked out by hand).
    tbl[0] = mk(4'd0, 2'd0, 5'd16, 1, 16'h0, {16{8'h01}}, {16{8'hFF}}, 0, 0, {4{32'h1234_5678}});
    tbl[0].exp_res = '0;                                  tbl[0].exp_ill = 0; tbl[0].exp_lat = 3;
    tbl[1] = mk(4'd12, 2'd2, 5'd4, 1, 16'h0, '0, {4{32'h0001_0000}}, 32'h0001_0000, 1, {16{8'h55}});
    tbl[1].exp_res = '0;                                  tbl[1].exp_ill = 0; tbl[1].exp_lat = 5;
    tbl[2] = mk(4'd1, 2'd1, 5'd5, 0, 16'h0015, {8{16'h0003}}, {8{16'h0010}}, 0, 0, {8{16'hAAAA}});
    tbl[2].exp_res = 128'hAAAA_AAAA_AAAA_000D_AAAA_000D_AAAA_000D;
    tbl[2].exp_ill = 0; tbl[2].exp_lat = 3;
    tbl[3] = mk(4'd0, 2'd3, 5'd8, 1, 16'h0, {16{8'h11}}, {16{8'h22}}, 0, 0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    tbl[3].exp_res = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE; tbl[3].exp_ill = 1; tbl[3].exp_lat = 1;
    tbl[4] = mk(4'd14, 2'd0, 5'd8, 1, 16'h0, {16{8'h11}}, {16{8'h22}}, 0, 0, {4{32'hCAFE_0001}});
    tbl[4].exp_res = {4{32'hCAFE_0001}};                  tbl[4].exp_ill = 1; tbl[4].exp_lat = 1;
    tbl[5] = mk(4'd0, 2'd0, 5'd0, 1, 16'h0, {16{8'h11}}, {16{8'h22}}, 0, 0, {4{32'h0BAD_F00D}});
    tbl[5].exp_res = {4{32'h0BAD_F00D}};                  tbl[5].exp_ill = 0; tbl[5].exp_lat = 1;
    tbl[6] = mk(4'd7, 2'd0, 5'd20, 1, 16'h0, '0, {16{8'h80}}, 32'h0000_000F, 1, '0);
    tbl[6].exp_res = {16{8'hFF}};                         tbl[6].exp_ill = 0; tbl[6].exp_lat = 3;
    tbl[7] = mk(4'd9, 2'd1, 5'd8, 1, 16'h0, {8{16'h0001}}, {8{16'h8000}}, 0, 0, '0);
    tbl[7].exp_res = {8{16'h8000}};                       tbl[7].exp_ill = 0; tbl[7].exp_lat = 3;
    tbl[8] = mk(4'd8, 2'd1, 5'd8, 1, 16'h0, {8{16'h0001}}, {8{16'h8000}}, 0, 0, '0);
    tbl[8].exp_res = {8{16'h0001}};                       tbl[8].exp_ill = 0; tbl[8].exp_lat = 3;
    tbl[9] = mk(4'd5, 2'd2, 5'd4, 1, 16'h0, '0, {4{32'h0000_0001}}, 32'h0000_0023, 1, '0);
    tbl[9].exp_res = {4{32'h0000_0008}};                  tbl[9].exp_ill = 0; tbl[9].exp_lat = 3;

    for (int i = NDIR; i < NVEC; i++) begin
      v = mk(4'($urandom_range(0, 12)), 2'($urandom_range(0, 2)), 5'($urandom_range(0, 20)),
             1'($urandom_range(0, 1)), 16'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             $urandom, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
      if (i % 10 == 9) v.sew = 2'd3;
      v.exp_res = model(v);
      v.exp_ill = (v.sew == 2'b11 || v.op > 4'd12);
      v.exp_lat = lat_of(v);
      tbl[i] = v;
    end

    // Reset values.
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 128'(ready_o), 128'(1));
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_illegal", 128'(illegal_o), 128'(0));
    chk("rst_result", result_o, '0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < NVEC; i++) begin
      issue(tbl[i], lat);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(tbl[i].exp_lat));
      chk($sformatf("vec%0d_result", i), result_o, tbl[i].exp_res);
      chk($sformatf("vec%0d_illegal", i), 128'(illegal_o), 128'(tbl[i].exp_ill));
      @(posedge clk_i); #1;
      chk($sformatf("vec%0d_released", i), 128'(valid_o), 128'(0));
    end

    // Output backpressure: result held, second request ignored.
    ready_i = 1'b0;
    issue(tbl[2], lat);
    chk("bp_latency", 128'(lat), 128'(3));
    v = tbl[0];
    drive(v);
    valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i); #1;
      chk("bp_valid_held", 128'(valid_o), 128'(1));
      chk("bp_result_held", result_o, tbl[2].exp_res);
      chk("bp_ready_low", 128'(ready_o), 128'(0));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("bp_no_second_accept", 128'(busy_o), 128'(0));
    chk("bp_valid_dropped", 128'(valid_o), 128'(0));

    // Flush during EXEC beat 0.
    issue_flush: begin
      drive(tbl[0]);
      valid_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      chk("flush_in_exec", 128'(busy_o), 128'(1));
      flush_i = 1'b1;
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      chk("flush_ready", 128'(ready_o), 128'(1));
      seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (valid_o) seen++;
        @(posedge clk_i); #1;
      end
      chk("flush_no_valid", 128'(seen), 128'(0));
    end

    // Flush wins over a same-cycle request.
    drive(tbl[0]);
    valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    chk("flush_blocks_accept", 128'(busy_o), 128'(0));

    // Async reset in the middle of a MUL.
    drive(tbl[1]);
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("mul_busy_before_rst", 128'(busy_o), 128'(1));
    rst_i = 1'b1;
    #1;
    chk("midrst_ready", 128'(ready_o), 128'(1));
    chk("midrst_busy", 128'(busy_o), 128'(0));
    chk("midrst_valid", 128'(valid_o), 128'(0));
    chk("midrst_illegal", 128'(illegal_o), 128'(0));
    chk("midrst_result", result_o, '0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    issue(tbl[1], lat);
    chk("post_rst_mul_latency", 128'(lat), 128'(5));
    chk("post_rst_mul_result", result_o, tbl[1].exp_res);
    @(posedge clk_i); #1;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
